// File: rtl/shift_rotate_unit_pkg.sv
// Shared definitions for the shift/rotate unit: op codes, FSM encoding and
// a constant-evaluable clog2 used to size the remaining-count register.
package shift_rotate_pkg;

    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_rotate_unit_if.sv
// Request/response bundle between a requester and the shift/rotate unit.
interface shift_rotate_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [31:0]      amount;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (output start, op, a, amount, input busy, done, result, err);
    modport slave  (input start, op, a, amount, output busy, done, result, err);
endinterface

// File: rtl/shift_rotate_unit_shift_step.sv
// Stateless single move of k positions; the double-width concatenation lets
// one shifter serve fill-shifts and rotates alike.
module shift_step
    import shift_rotate_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int KW    = 6
) (
    input  logic [WIDTH-1:0] din,
    input  logic [2:0]       op,
    input  logic             fill,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] dout
);
    logic [2*WIDTH-1:0] wide;

    always_comb begin
        wide = '0;
        dout = din;
        case (op)
            OP_SHR, OP_SHRA: begin
                wide = {{WIDTH{fill}}, din} >> k;
                dout = wide[WIDTH-1:0];
            end
            OP_SHL: begin
                wide = {din, {WIDTH{1'b0}}} << k;
                dout = wide[2*WIDTH-1:WIDTH];
            end
            OP_ROR: begin
                wide = {din, din} >> k;
                dout = wide[WIDTH-1:0];
            end
            OP_ROL: begin
                wide = {din, din} << k;
                dout = wide[2*WIDTH-1:WIDTH];
            end
            default: dout = din;
        endcase
    end
endmodule

// File: rtl/shift_rotate_unit.sv
// Multi-cycle shifter/rotator: captures an operand, moves it up to STEP
// positions per cycle, and presents a registered result with a done pulse.
module shift_rotate_unit
    import shift_rotate_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic          clock,
    input  logic          clear,
    shift_rotate_unit_if.slave bus
);
    localparam int LW = clog2(WIDTH);
    localparam int CW = LW + 1;
    localparam logic [CW-1:0] STEP_C  = CW'(STEP);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    remaining_q, remaining_d, k, eff_cnt;
    logic [WIDTH-1:0] work_q, work_d, step_out, result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic             fill_q, fill_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic             illegal, accept;

    // Rotates wrap the count; shifts saturate at WIDTH using the full amount.
    always_comb begin
        illegal = bus.op > OP_ROL;
        accept  = (state_q == S_IDLE) && bus.start;
        eff_cnt = {1'b0, bus.amount[LW-1:0]};
        if (bus.op != OP_ROR && bus.op != OP_ROL && bus.amount >= 32'(WIDTH))
            eff_cnt = WIDTH_C;
        k = (remaining_q < STEP_C) ? remaining_q : STEP_C;
    end

    shift_step #(.WIDTH(WIDTH), .KW(CW)) u_step (
        .din  (work_q),
        .op   (op_q),
        .fill (fill_q),
        .k    (k),
        .dout (step_out)
    );

    always_ff @(posedge clock) begin
        if (clear) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = (illegal || eff_cnt == '0) ? S_DONE : S_RUN;
            S_RUN:  if (remaining_q <= k) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        work_d      = work_q;
        remaining_d = remaining_q;
        op_d        = op_q;
        fill_d      = fill_q;
        result_d    = result_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: if (accept) begin
                op_d        = bus.op;
                work_d      = bus.a;
                fill_d      = (bus.op == OP_SHRA) & bus.a[WIDTH-1];
                remaining_d = illegal ? '0 : eff_cnt;
                if (illegal || eff_cnt == '0) begin
                    result_d = bus.a;
                    err_d    = illegal;
                end
            end
            S_RUN: begin
                work_d      = step_out;
                remaining_d = remaining_q - k;
                if (remaining_q <= k) begin
                    result_d = step_out;
                    err_d    = 1'b0;
                end
            end
            default: ;
        endcase
        busy_d = state_d != S_IDLE;
        done_d = state_d == S_DONE;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            work_q      <= '0;
            remaining_q <= '0;
            op_q        <= '0;
            fill_q      <= 1'b0;
            result_q    <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            work_q      <= work_d;
            remaining_q <= remaining_d;
            op_q        <= op_d;
            fill_q      <= fill_d;
            result_q    <= result_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_shift_rotate_unit.sv
// Directed scoreboard bench: two units (STEP=1 and STEP=8) share one clock.
module tb_shift_rotate_unit;
    logic clock = 1'b0;
    logic clear = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    shift_rotate_unit_if #(.WIDTH(32)) bus1 ();
    shift_rotate_unit_if #(.WIDTH(32)) bus2 ();

    shift_rotate_unit #(.WIDTH(32), .STEP(1)) dut1 (.clock(clock), .clear(clear), .bus(bus1));
    shift_rotate_unit #(.WIDTH(32), .STEP(8)) dut2 (.clock(clock), .clear(clear), .bus(bus2));

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          t0;
        int          lat;
        string       nm;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drv(input int sel, input logic st, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] amt);
        if (sel == 1) begin
            bus2.start = st; bus2.op = op; bus2.a = a; bus2.amount = amt;
        end else begin
            bus1.start = st; bus1.op = op; bus1.a = a; bus1.amount = amt;
        end
    endtask

    // Monitors: pop one expectation per done pulse
    always @(negedge clock) begin
        exp_t e;
        if (bus1.done) begin
            if (q0.size() == 0) chk("unexpected done dut1", 1, 0);
            else begin
                e = q0.pop_front();
                chk({e.nm, " result"}, bus1.result, e.res);
                chk({e.nm, " err"}, bus1.err, e.err);
                chk({e.nm, " latency"}, cyc - e.t0, e.lat);
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (bus2.done) begin
            if (q1.size() == 0) chk("unexpected done dut2", 1, 0);
            else begin
                e = q1.pop_front();
                chk({e.nm, " result"}, bus2.result, e.res);
                chk({e.nm, " err"}, bus2.err, e.err);
                chk({e.nm, " latency"}, cyc - e.t0, e.lat);
            end
        end
    end

    task automatic run_op(input int sel, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] amt, input logic [31:0] er, input logic ee,
                          input int lat, input string nm, input bit glitch);
        exp_t e;
        bit   got;
        @(negedge clock);
        drv(sel, 1'b1, op, a, amt);
        e.res = er; e.err = ee; e.t0 = cyc + 1; e.lat = lat; e.nm = nm;
        if (sel == 1) q1.push_back(e);
        else          q0.push_back(e);
        @(posedge clock);
        #1 drv(sel, 1'b0, 3'd6, ~a, ~amt);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clock);
            chk({nm, " busy"}, (sel == 1) ? bus2.busy : bus1.busy, 1);
            if ((sel == 1) ? bus2.done : bus1.done) got = 1'b1;
            if (glitch && (i == 1 || got)) drv(sel, 1'b1, 3'd2, 32'h0000FFFF, 32'd1);
            else                           drv(sel, 1'b0, 3'd6, ~a, ~amt);
        end
        if (!got) chk({nm, " timeout"}, 0, 1);
        @(negedge clock);
        drv(sel, 1'b0, 3'd0, 32'h0, 32'h0);
        chk({nm, " busy after"}, (sel == 1) ? bus2.busy : bus1.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // clear held with start asserted: clear must win
        drv(0, 1'b1, 3'd3, 32'h000000F1, 32'd4);
        drv(1, 1'b1, 3'd3, 32'h000000F1, 32'd4);
        repeat (3) @(negedge clock);
        chk("reset busy", bus1.busy, 0);
        chk("reset done", bus1.done, 0);
        chk("reset err", bus1.err, 0);
        chk("reset result", bus1.result, 0);
        chk("reset busy dut2", bus2.busy, 0);
        chk("reset result dut2", bus2.result, 0);
        clear = 1'b0;
        drv(0, 1'b0, 3'd0, 32'h0, 32'h0);
        drv(1, 1'b0, 3'd0, 32'h0, 32'h0);
        @(negedge clock);
        chk("idle after reset", bus1.busy, 0);

        run_op(0, 3'd3, 32'h000000F1, 32'd4,  32'h1000000F, 1'b0, 4,  "ror4", 1'b0);
        run_op(0, 3'd3, 32'h000000F1, 32'd36, 32'h1000000F, 1'b0, 4,  "ror36", 1'b0);
        run_op(0, 3'd4, 32'hDEADBEEF, 32'd0,  32'hDEADBEEF, 1'b0, 0,  "rol0", 1'b0);
        run_op(0, 3'd1, 32'h80000000, 32'd40, 32'hFFFFFFFF, 1'b0, 32, "shra40", 1'b0);
        run_op(0, 3'd0, 32'h80000000, 32'd40, 32'h00000000, 1'b0, 32, "shr40", 1'b0);
        run_op(0, 3'd7, 32'h12345678, 32'd5,  32'h12345678, 1'b1, 0,  "illegal", 1'b0);
        run_op(0, 3'd2, 32'h00000001, 32'd4,  32'h00000010, 1'b0, 4,  "shl4", 1'b0);
        run_op(0, 3'd4, 32'h80000001, 32'd1,  32'h00000003, 1'b0, 1,  "rol1", 1'b0);
        run_op(0, 3'd0, 32'hF0000000, 32'd4,  32'h0F000000, 1'b0, 4,  "shr4", 1'b0);
        run_op(0, 3'd1, 32'hF0000000, 32'd4,  32'hFF000000, 1'b0, 4,  "shra4", 1'b0);
        run_op(0, 3'd2, 32'hFFFFFFFF, 32'd32, 32'h00000000, 1'b0, 32, "shl32", 1'b0);
        run_op(0, 3'd1, 32'h80000000, 32'd32, 32'hFFFFFFFF, 1'b0, 32, "shra32", 1'b0);
        run_op(0, 3'd2, 32'h00000001, 32'h80000004, 32'h00000000, 1'b0, 32, "shl_big", 1'b0);
        run_op(0, 3'd3, 32'h000000F1, 32'd4,  32'h1000000F, 1'b0, 4,  "ror4 glitch", 1'b1);

        run_op(1, 3'd2, 32'h00000001, 32'd20, 32'h00100000, 1'b0, 3,  "s8 shl20", 1'b0);
        run_op(1, 3'd3, 32'h000000F1, 32'd12, 32'h0F100000, 1'b0, 2,  "s8 ror12", 1'b0);
        run_op(1, 3'd1, 32'h80000000, 32'd40, 32'hFFFFFFFF, 1'b0, 4,  "s8 shra40", 1'b0);

        // abort mid-RUN: no done, result cleared
        @(negedge clock);
        drv(0, 1'b1, 3'd3, 32'h000000F1, 32'd8);
        @(negedge clock);
        drv(0, 1'b0, 3'd0, 32'h0, 32'h0);
        repeat (2) @(negedge clock);
        chk("abort busy before", bus1.busy, 1);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk("abort busy", bus1.busy, 0);
        chk("abort result", bus1.result, 0);
        chk("abort done", bus1.done, 0);
        repeat (15) @(negedge clock);
        chk("abort stays idle", bus1.busy, 0);

        chk("queue dut1 empty", q0.size(), 0);
        chk("queue dut2 empty", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_rotate_unit.md
SHIFT_ROTATE_UNIT -- requirements
Module: shift_rotate_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; SHALL be a power of two, at least 8.
REQ-002 Parameter STEP, default 1: maximum bit positions moved per RUN cycle; SHALL be between 1 and WIDTH.
REQ-003 clock  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 clear  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 op  input  3  operation: 000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL; 101-111 illegal.
REQ-007 a  input  WIDTH  operand; captured on an accepted start.
REQ-008 amount  input  32  unsigned shift/rotate count; captured on an accepted start.
REQ-009 busy  output  1  high from the cycle after an accepted start until the done cycle, inclusive.
REQ-010 done  output  1  one-cycle pulse marking result valid.
REQ-011 result  output  WIDTH  registered result; held until the next done.
REQ-012 err  output  1  illegal op flag; valid with done, held with result.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE. IDLE goes to RUN on start when the effective count is nonzero, or to DONE when it is zero. RUN goes to DONE when the remaining count reaches 0. DONE goes to IDLE unconditionally.
REQ-014 Effective count for ROR/ROL SHALL be amount mod WIDTH; for SHR/SHRA/SHL it SHALL be min(amount, WIDTH), with the full 32-bit amount compared.
REQ-015 Each RUN cycle SHALL move the working register by k = min(STEP, remaining) positions and decrement remaining by k.
REQ-016 SHR fills with 0; SHRA fills with the captured operand MSB; SHL fills with 0; ROR moves bit 0 into the MSB; ROL moves the MSB into bit 0.
REQ-017 Latency: start accepted at edge t; done SHALL be high in cycle t+N+1, where N = ceil(effective/STEP); N=0 gives done at t+1.
REQ-018 result and err SHALL update on the edge entering DONE and not otherwise.
REQ-019 An illegal op SHALL go IDLE to DONE directly, with result = a and err = 1. A legal op SHALL set err = 0.
REQ-020 start while busy or in DONE SHALL be ignored, with no effect on state, result or a later done.
REQ-021 Changes on a, amount or op after capture SHALL have no effect on the operation in flight.
REQ-022 A count of exactly WIDTH for shifts SHALL give all-fill (0, or sign replication for SHRA).

Reset
REQ-023 With clear high at an edge, the block SHALL enter IDLE with busy=0, done=0, err=0, result=0 and remaining=0.
REQ-024 clear SHALL override start in the same cycle.
REQ-025 clear mid-RUN SHALL abort the operation with no done pulse, and result SHALL read 0 on the following cycle.

Structure
REQ-026 A shared package shift_rotate_pkg SHALL hold: op code constants, FSM state encoding, and a clog2 function for the counter width.
REQ-027 The remaining counter SHALL be clog2(WIDTH)+1 bits wide.
REQ-028 One combinational sub-module shift_step SHALL perform a single move of k positions (k at most STEP) for a given op and fill bit; it SHALL hold no state.
REQ-029 No combinational path SHALL run from inputs to outputs; busy, done, result and err SHALL be registered.

Verification
REQ-030 WIDTH=32, STEP=1: ROR a=0x000000F1, amount=4 -> result 0x1000000F, done at t+5, busy high in cycles t+1..t+5.
REQ-031 ROR amount=36 -> same result as amount=4 (0x1000000F). ROL amount=0 -> result=a, done at t+1.
REQ-032 SHRA a=0x80000000, amount=40 -> result 0xFFFFFFFF, done at t+33. SHR of the same operand -> 0x00000000.
REQ-033 start pulsed during RUN -> ignored, one done only. clear mid-RUN -> busy=0 and result=0 next cycle, no done.
REQ-034 op=111, a=0x12345678 -> done at t+1, result 0x12345678, err=1. A following legal op -> err=0.
REQ-035 WIDTH=32, STEP=8: SHL a=0x00000001, amount=20 -> result 0x00100000, done at t+4.
